// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue block.
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the issue-side, ALU-side and writeback-side signals of alu_issue.
// master: the issue block itself; slave: its environment (decoder stage,
// ALU and writeback stage).
interface alu_issue_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int OP_WIDTH       = 4,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               instr;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [OP_WIDTH-1:0]       alu_op;
    logic [DATA_WIDTH-1:0]     alu_a;
    logic [DATA_WIDTH-1:0]     alu_b;
    logic [DATA_WIDTH-1:0]     alu_out;
    logic                      alu_fault;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     result;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      fault;

    modport master (
        input  in_valid, instr, rs1_data, rs2_data, alu_out, alu_fault, out_ready,
        output in_ready, alu_op, alu_a, alu_b, out_valid, result, rd, fault
    );

    modport slave (
        output in_valid, instr, rs1_data, rs2_data, alu_out, alu_fault, out_ready,
        input  in_ready, alu_op, alu_a, alu_b, out_valid, result, rd, fault
    );
endinterface

// File: rtl/alu_decode.sv
// Combinational decode of RV32I/E OP and OP-IMM instructions into ALU op,
// operand-B select and sign-extended immediate.
// Optional macro RV32E_EN: also reject references to x16..x31.
module alu_decode
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic [31:0]           instr,
    output logic                  legal,
    output logic [OP_WIDTH-1:0]   op,
    output logic                  use_imm,
    output logic [DATA_WIDTH-1:0] imm
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       base_legal;
    logic       is_op;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm    = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign unused_fields = ^instr[19:7];

    // Opcode/funct legality and ALU op selection
    always_comb begin
        base_legal = 1'b0;
        is_op      = 1'b0;
        use_imm    = 1'b0;
        op         = '0;
        if (opcode == OPC_OP) begin
            is_op      = 1'b1;
            base_legal = (funct7 == F7_BASE) ||
                         ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            op         = OP_WIDTH'({funct7[5], funct3});
        end else if (opcode == OPC_OP_IMM) begin
            use_imm = 1'b1;
            if (funct3 == 3'b001) begin
                base_legal = (funct7 == F7_BASE);
                op         = OP_WIDTH'({1'b0, funct3});
            end else if (funct3 == 3'b101) begin
                base_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                op         = OP_WIDTH'({instr[30], funct3});
            end else begin
                base_legal = 1'b1;
                op         = OP_WIDTH'({1'b0, funct3});
            end
        end
    end

`ifdef RV32E_EN
    // Only x0..x15 exist; rs2 is a register field for OP only
    assign legal = base_legal && !instr[11] && !instr[19] && !(is_op && instr[24]);
`else
    logic unused_is_op;
    assign unused_is_op = is_op;
    assign legal        = base_legal;
`endif

endmodule

// File: rtl/alu_issue.sv
// Issues one decoded math instruction to a registered one-cycle ALU and hands
// the result to writeback over a valid/ready handshake.
// Optional macro RV32E_EN (in alu_decode): restrict to x0..x15.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | in_ready=1, waiting for an instruction
// EXEC    | alu_op/alu_a/alu_b driven, ALU samples them at end of cycle
// CAPTURE | alu_out/alu_fault valid, latched into result/fault
// DONE    | out_valid=1, result/rd/fault held until out_ready
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OP_WIDTH       = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic      clk,
    input  logic      reset,
    alu_issue_if.master bus
);
    state_t                    state;
    state_t                    state_nxt;
    logic                      accept;
    logic                      dec_legal;
    logic                      dec_use_imm;
    logic [OP_WIDTH-1:0]       dec_op;
    logic [DATA_WIDTH-1:0]     dec_imm;
    logic [OP_WIDTH-1:0]       alu_op_q;
    logic [DATA_WIDTH-1:0]     alu_a_q;
    logic [DATA_WIDTH-1:0]     alu_b_q;
    logic [DATA_WIDTH-1:0]     result_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      fault_q;

    alu_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .OP_WIDTH   (OP_WIDTH)
    ) u_decode (
        .instr   (bus.instr),
        .legal   (dec_legal),
        .op      (dec_op),
        .use_imm (dec_use_imm),
        .imm     (dec_imm)
    );

    assign accept = bus.in_valid && (state == ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; an illegal instruction skips the ALU entirely
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept) state_nxt = dec_legal ? ST_EXEC : ST_DONE;
            ST_EXEC:    state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_DONE;
            ST_DONE:    if (bus.out_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // ALU operand registers and writeback result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            result_q <= '0;
            rd_q     <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (accept) begin
                rd_q <= bus.instr[7 +: REG_ADDR_WIDTH];
                if (dec_legal) begin
                    alu_op_q <= dec_op;
                    alu_a_q  <= bus.rs1_data;
                    alu_b_q  <= dec_use_imm ? dec_imm : bus.rs2_data;
                end else begin
                    result_q <= '0;
                    fault_q  <= 1'b1;
                end
            end
            if (state == ST_CAPTURE) begin
                result_q <= bus.alu_fault ? '0 : bus.alu_out;
                fault_q  <= bus.alu_fault;
            end
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.result    = result_q;
    assign bus.rd        = rd_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a registered one-cycle ALU model.
module tb_alu_issue;

    logic clk;
    logic reset;
    logic force_fault;
    int   n_checks;
    int   n_errors;

    alu_issue_if #(.DATA_WIDTH(32), .OP_WIDTH(4), .REG_ADDR_WIDTH(5)) bus ();

    alu_issue #(
        .DATA_WIDTH     (32),
        .OP_WIDTH       (4),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU: result valid the cycle after alu_* are sampled
    always @(posedge clk) begin
        logic [31:0] r;
        logic        f;
        f = 1'b0;
        case (bus.alu_op)
            4'b0000: r = bus.alu_a + bus.alu_b;
            4'b0001: r = bus.alu_a << bus.alu_b[4:0];
            4'b0010: r = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            4'b0011: r = {31'd0, bus.alu_a < bus.alu_b};
            4'b0100: r = bus.alu_a ^ bus.alu_b;
            4'b0101: r = bus.alu_a >> bus.alu_b[4:0];
            4'b0110: r = bus.alu_a | bus.alu_b;
            4'b0111: r = bus.alu_a & bus.alu_b;
            4'b1000: r = bus.alu_a - bus.alu_b;
            4'b1101: r = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
            default: begin r = 32'hDEAD_BEEF; f = 1'b1; end
        endcase
        bus.alu_out   <= r;
        bus.alu_fault <= f | force_fault;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one instruction, check ALU drive, latency, result, optional hold
    task automatic run_op(input string tag, input logic [31:0] ins,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit ff, input int e_lat,
                          input logic [3:0] e_op, input logic [31:0] e_a, input logic [31:0] e_b,
                          input logic [31:0] e_res, input logic [4:0] e_rd, input bit e_fault,
                          input int hold);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.rs1_data = a;
        bus.rs2_data = b;
        force_fault  = ff;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, ".alu_op"}, {28'd0, bus.alu_op}, {28'd0, e_op});
        check({tag, ".alu_a"}, bus.alu_a, e_a);
        check({tag, ".alu_b"}, bus.alu_b, e_b);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        force_fault = 1'b0;
        check({tag, ".latency"}, lat, e_lat);
        check({tag, ".result"}, bus.result, e_res);
        check({tag, ".rd"}, {27'd0, bus.rd}, {27'd0, e_rd});
        check({tag, ".fault"}, {31'd0, bus.fault}, {31'd0, e_fault});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            check({tag, ".hold_ready"}, {31'd0, bus.in_ready}, 32'd0);
            check({tag, ".hold_result"}, bus.result, e_res);
            check({tag, ".hold_rd"}, {27'd0, bus.rd}, {27'd0, e_rd});
            check({tag, ".hold_fault"}, {31'd0, bus.fault}, {31'd0, e_fault});
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".release_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, ".release_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        bit seen_valid;
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        force_fault   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = 32'd0;
        bus.rs1_data  = 32'd0;
        bus.rs2_data  = 32'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.result", bus.result, 32'd0);
        check("rst.rd", {27'd0, bus.rd}, 32'd0);
        check("rst.fault", {31'd0, bus.fault}, 32'd0);
        check("rst.alu_op", {28'd0, bus.alu_op}, 32'd0);
        check("rst.alu_a", bus.alu_a, 32'd0);
        check("rst.alu_b", bus.alu_b, 32'd0);

        //     tag      instr         rs1           rs2         ff lat op     a             b             result        rd     flt hold
        run_op("add",   32'h002081B3, 32'd5,        32'd7,      0, 3, 4'h0, 32'd5,        32'd7,        32'd12,       5'd3,  0, 0);
        run_op("addi",  32'hFFF08293, 32'd1,        32'h1234,   0, 3, 4'h0, 32'd1,        32'hFFFFFFFF, 32'd0,        5'd5,  0, 0);
        run_op("srai",  32'h4040D213, 32'h80000000, 32'd0,      0, 3, 4'hD, 32'h80000000, 32'h00000404, 32'hF8000000, 5'd4,  0, 0);
        run_op("badf7", 32'h4020A333, 32'd1,        32'd2,      0, 1, 4'hD, 32'h80000000, 32'h00000404, 32'd0,        5'd6,  1, 0);
        run_op("sub",   32'h402083B3, 32'd3,        32'd5,      0, 3, 4'h8, 32'd3,        32'd5,        32'hFFFFFFFE, 5'd7,  0, 5);
        run_op("bslli", 32'h40009013, 32'd9,        32'd9,      0, 1, 4'h8, 32'd3,        32'd5,        32'd0,        5'd0,  1, 0);
        run_op("lui",   32'h000004B7, 32'd9,        32'd9,      0, 1, 4'h8, 32'd3,        32'd5,        32'd0,        5'd9,  1, 0);
        run_op("aluflt",32'h0020C533, 32'hF0,       32'h0F,     1, 3, 4'h4, 32'hF0,       32'h0F,       32'd0,        5'd10, 1, 0);
        run_op("andi",  32'h0F00F593, 32'hABCD,     32'd0,      0, 3, 4'h7, 32'hABCD,     32'h000000F0, 32'h000000C0, 5'd11, 0, 0);
`ifdef RV32E_EN
        run_op("x16",   32'h00208833, 32'd20,       32'd22,     0, 1, 4'h7, 32'hABCD,     32'h000000F0, 32'd0,        5'd16, 1, 0);
`else
        run_op("x16",   32'h00208833, 32'd20,       32'd22,     0, 3, 4'h0, 32'd20,       32'd22,       32'd42,       5'd16, 0, 0);
`endif

        // Reset while the ALU operation is in flight
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instr    = 32'h002081B3;
        bus.rs1_data = 32'd100;
        bus.rs2_data = 32'd200;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("mid.exec_op_a", bus.alu_a, 32'd100);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mid.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid.result", bus.result, 32'd0);
        check("mid.rd", {27'd0, bus.rd}, 32'd0);
        check("mid.fault", {31'd0, bus.fault}, 32'd0);
        check("mid.alu_op", {28'd0, bus.alu_op}, 32'd0);
        check("mid.alu_a", bus.alu_a, 32'd0);
        check("mid.alu_b", bus.alu_b, 32'd0);
        seen_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen_valid = 1'b1;
        end
        check("mid.no_valid", {31'd0, seen_valid}, 32'd0);
        check("mid.idle_ready", {31'd0, bus.in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Driver side of the registered ALU interface; the ALU itself computes one cycle after sampling op/in_a/in_b.
- Accepts one RV32I/E math instruction (OP 0110011 / OP-IMM 0010011) plus rs1/rs2 values over a valid/ready handshake.
- Decodes the instruction into ALU op and operands, drives the ALU, and waits out its one-cycle latency.
- Returns result, rd and a fault flag to the writeback stage over a second valid/ready handshake.

Parameters:
DATA_WIDTH, 32, operand/result width
OP_WIDTH, 4, ALU op code width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  instruction/operands offered
in_ready  output  1  block can accept (high only in IDLE)
instr  input  32  instruction word
rs1_data  input  DATA_WIDTH  rs1 value
rs2_data  input  DATA_WIDTH  rs2 value
alu_op  output  OP_WIDTH  op to ALU (registered)
alu_a  output  DATA_WIDTH  ALU bus A (registered)
alu_b  output  DATA_WIDTH  ALU bus B (registered)
alu_out  input  DATA_WIDTH  ALU result, valid the cycle after sampling
alu_fault  input  1  ALU invalid-op flag, same timing as alu_out
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  DATA_WIDTH  computed value (0 on fault)
rd  output  REG_ADDR_WIDTH  destination register (instr[11:7])
fault  output  1  illegal instruction or ALU fault

Behaviour:
- Reset values: state=IDLE; in_ready=1; out_valid=0; result=0; rd=0; fault=0; alu_op=0; alu_a=0; alu_b=0.
- FSM states: IDLE, EXEC, CAPTURE, DONE.
- IDLE, accept (in_valid & in_ready):
  - rd latched from instr[11:7].
  - If legal: register alu_op/alu_a/alu_b, go to EXEC.
  - If illegal: go to DONE with fault=1, result=0; ALU outputs keep previous values (no issue).
- EXEC: ALU samples alu_* at the end of this cycle. Go to CAPTURE.
- CAPTURE: latch result=alu_out and fault=alu_fault. If alu_fault, result=0. Go to DONE.
- DONE: out_valid=1, with result/rd/fault held stable. Stay until out_ready=1, then go to IDLE.
- No accept in the same cycle as a DONE handshake; in_ready is a function of state only.
- Latency: out_valid rises 3 cycles after the accept edge for legal instructions, 1 cycle for illegal ones.
- alu_op/alu_a/alu_b hold their values between issues.
- Decode, OP (0110011):
  - funct7 must be 0000000 or 0100000; 0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
  - alu_op={funct7[5],funct3}; alu_b=rs2_data.
- Decode, OP-IMM (0010011):
  - alu_b = instr[31:20] sign-extended to DATA_WIDTH.
  - alu_op={0,funct3}, except funct3=101, where alu_op={instr[30],101}.
  - funct3=001 requires instr[31:25]=0000000.
  - funct3=101 requires instr[31:25] = 0000000 or 0100000.
  - For shifts, alu_b is the sign-extended immediate; the ALU uses bits [4:0] only.
- alu_a=rs1_data in all legal cases.
- Any other opcode is illegal.
- Reset mid-operation: returns to IDLE with all outputs at reset values. An ALU result still in flight is ignored.

Optional Feature:
Macro: RV32E_EN
- With RV32E_EN defined: an instruction is also illegal if instr[11] (rd), instr[19] (rs1) or, for OP only, instr[24] (rs2) is 1, i.e. it references x16–x31.
- Without RV32E_EN: all 32 register indices are legal.

Decomposition:
Shared package alu_pkg holds:
- Opcode constants OPC_OP, OPC_OP_IMM.
- ALU op constants ALU_ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND, SUB, SRA (4'b0000…4'b1101).
- FSM state enum typedef.
- funct7 constants F7_BASE, F7_ALT.

One combinational sub-module, alu_decode, is natural: instr in → legal, op, use_imm, imm out. alu_issue instantiates it and owns the FSM and registers.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7 (instr 0x002081B3) → out_valid 3 cycles after accept; result=12, rd=3, fault=0; alu_op=0000 during EXEC.
- ADDI x5,x1,-1 (imm 0xFFF) with rs1=1 → alu_b=0xFFFFFFFF, result=0, rd=5, fault=0.
- SRAI x4,x1,4 with rs1=0x80000000 → alu_op=1101, result=0xF8000000.
- OP with funct7=0100000, funct3=010 → fault=1, result=0, out_valid 1 cycle after accept; alu_* unchanged.
- Hold out_ready=0 for 5 cycles in DONE → out_valid, result, rd and fault stable, in_ready=0; out_ready=1 → IDLE and in_ready=1 next cycle.
- Reset asserted during EXEC → next cycle IDLE with all outputs at reset values; no out_valid follows. With RV32E_EN: ADD x16,x1,x2 → fault=1.
